// File: rtl/bsg_tag_pkg.sv
// Shared helpers for bsg_tag protocol blocks: width math and packet framing sizes.
package bsg_tag_pkg;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // Start bit + node id + data_not_reset + length field.
  function automatic int tag_header_len(input int id_width, input int lg_width);
    return 1 + id_width + 1 + lg_width;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bsg_gateway_tag_packet_decoder_if.sv
// Decoded tag packet valid/ready bus between the decoder and its consumer.
interface bsg_gateway_tag_packet_decoder_if
  import bsg_tag_pkg::*;
#(
  parameter int id_width_p      = 6,
  parameter int lg_width_p      = 4,
  parameter int payload_width_p = 15
);
  logic                       v_o;
  logic                       ready_i;
  logic [id_width_p-1:0]      node_id_o;
  logic                       data_not_reset_o;
  logic [lg_width_p-1:0]      len_o;
  logic [payload_width_p-1:0] payload_o;

  modport master (output v_o, node_id_o, data_not_reset_o, len_o, payload_o,
                  input  ready_i);
  modport slave  (input  v_o, node_id_o, data_not_reset_o, len_o, payload_o,
                  output ready_i);
endinterface

// File: rtl/bsg_gateway_tag_deserializer.sv
// LSB-first field accumulator; clears itself when the requested field length is reached.
module bsg_gateway_tag_deserializer
  import bsg_tag_pkg::*;
#(
  parameter int width_p     = 15,
  parameter int cnt_width_p = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   shift_i,
  input  logic                   clear_i,
  input  logic                   data_i,
  input  logic [cnt_width_p-1:0] field_len_i,
  output logic [width_p-1:0]     field_o,
  output logic                   field_done_o
);
  logic [width_p-1:0]     shreg_q, shreg_d;
  logic [cnt_width_p-1:0] cnt_q, cnt_d;
  logic [width_p-1:0]     merged;

  // field_o includes the bit being sampled now so the caller can capture on the final bit.
  always_comb begin
    merged = shreg_q;
    for (int unsigned i = 0; i < width_p; i++) begin
      if (32'(cnt_q) == i) merged[i] = data_i;
    end
  end

  assign field_o      = merged;
  assign field_done_o = shift_i && ((cnt_q + cnt_width_p'(1)) == field_len_i);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear_i || field_done_o) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = merged;
      cnt_d   = cnt_q + cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/bsg_gateway_tag_packet_decoder.sv
// Rebuilds bsg_tag packets from the sampled (en, data) stream and detects master-reset runs.
module bsg_gateway_tag_packet_decoder
  import bsg_tag_pkg::*;
#(
  parameter int els_p               = 64,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 15,
  parameter int reset_run_p         = 32
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic data_i,
  bsg_gateway_tag_packet_decoder_if.master pkt_if,
  output logic sync_reset_o,
  output logic overrun_o,
  output logic malformed_o
);
  localparam int id_width_lp    = safe_clog2(els_p);
  localparam int field_max_lp   = max3(id_width_lp, lg_width_p, (1 << lg_width_p) - 1);
  localparam int cnt_width_lp   = safe_clog2(field_max_lp + 1);
  localparam int shreg_width_lp = max3(id_width_lp, lg_width_p, max_payload_width_p);
  localparam int ones_width_lp  = safe_clog2(reset_run_p + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ID        = 3'd1;
  localparam logic [2:0] DNR       = 3'd2;
  localparam logic [2:0] LEN       = 3'd3;
  localparam logic [2:0] PAYLOAD   = 3'd4;
  localparam logic [2:0] WAIT_ZERO = 3'd5;

  typedef struct packed {
    logic [id_width_lp-1:0]         node_id;
    logic                           data_not_reset;
    logic [lg_width_p-1:0]          len;
    logic [max_payload_width_p-1:0] payload;
  } pkt_s;

  logic [2:0]               state_q, state_d;
  logic [ones_width_lp-1:0] ones_q, ones_d;
  logic [id_width_lp-1:0]   id_q, id_d;
  logic                     dnr_q, dnr_d;
  logic [lg_width_p-1:0]    len_q, len_d;
  pkt_s                     out_q, out_d, new_pkt;
  logic                     v_q, v_d;
  logic                     sync_q, sync_d;
  logic                     overrun_q, overrun_d;
  logic                     malformed_q, malformed_d;

  logic                      shift, clear, field_done, complete, run_hit;
  logic [cnt_width_lp-1:0]   field_len;
  logic [shreg_width_lp-1:0] field;

  bsg_gateway_tag_deserializer #(
    .width_p    (shreg_width_lp),
    .cnt_width_p(cnt_width_lp)
  ) deser (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .shift_i     (shift),
    .clear_i     (clear),
    .data_i      (data_i),
    .field_len_i (field_len),
    .field_o     (field),
    .field_done_o(field_done)
  );

  always_comb begin
    case (state_q)
      ID:      field_len = cnt_width_lp'(id_width_lp);
      DNR:     field_len = cnt_width_lp'(1);
      LEN:     field_len = cnt_width_lp'(lg_width_p);
      default: field_len = cnt_width_lp'(len_q);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    id_d        = id_q;
    dnr_d       = dnr_q;
    len_d       = len_q;
    out_d       = out_q;
    v_d         = v_q && !pkt_if.ready_i;
    sync_d      = 1'b0;
    overrun_d   = overrun_q;
    malformed_d = malformed_q;
    shift       = 1'b0;
    clear       = 1'b0;
    complete    = 1'b0;
    run_hit     = 1'b0;
    new_pkt     = '0;

    if (en_i) begin
      if (data_i) begin
        if (ones_q != ones_width_lp'(reset_run_p)) ones_d = ones_q + ones_width_lp'(1);
        run_hit = (ones_q == ones_width_lp'(reset_run_p - 1));
      end else begin
        ones_d = '0;
      end

      if (run_hit) begin
        sync_d  = 1'b1;
        clear   = 1'b1;
        state_d = WAIT_ZERO;
      end else begin
        case (state_q)
          IDLE: if (data_i) state_d = ID;
          ID: begin
            shift = 1'b1;
            if (field_done) begin
              id_d    = field[id_width_lp-1:0];
              state_d = DNR;
            end
          end
          DNR: begin
            shift = 1'b1;
            if (field_done) begin
              dnr_d   = field[0];
              state_d = LEN;
            end
          end
          LEN: begin
            shift = 1'b1;
            if (field_done) begin
              len_d = field[lg_width_p-1:0];
              if (field[lg_width_p-1:0] == '0) begin
                complete = 1'b1;
                state_d  = IDLE;
              end else begin
                state_d = PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            shift = 1'b1;
            if (field_done) begin
              complete = 1'b1;
              state_d  = IDLE;
            end
          end
          WAIT_ZERO: if (!data_i) state_d = IDLE;
          default:   state_d = IDLE;
        endcase
      end
    end

    // A zero-length packet completes out of LEN, so its len/payload are zero by construction.
    if (complete) begin
      new_pkt.node_id        = id_q;
      new_pkt.data_not_reset = dnr_q;
      new_pkt.len            = (state_q == PAYLOAD) ? len_q : '0;
      new_pkt.payload        = (state_q == PAYLOAD) ? field[max_payload_width_p-1:0] : '0;
      if ((32'(id_q) >= els_p) || (32'(new_pkt.len) > max_payload_width_p)) begin
        malformed_d = 1'b1;
      end else if (v_q && !pkt_if.ready_i) begin
        overrun_d = 1'b1;
      end else begin
        out_d = new_pkt;
        v_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ones_q      <= '0;
      id_q        <= '0;
      dnr_q       <= 1'b0;
      len_q       <= '0;
      out_q       <= '0;
      v_q         <= 1'b0;
      sync_q      <= 1'b0;
      overrun_q   <= 1'b0;
      malformed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      id_q        <= id_d;
      dnr_q       <= dnr_d;
      len_q       <= len_d;
      out_q       <= out_d;
      v_q         <= v_d;
      sync_q      <= sync_d;
      overrun_q   <= overrun_d;
      malformed_q <= malformed_d;
    end
  end

  assign pkt_if.v_o              = v_q;
  assign pkt_if.node_id_o        = out_q.node_id;
  assign pkt_if.data_not_reset_o = out_q.data_not_reset;
  assign pkt_if.len_o            = out_q.len;
  assign pkt_if.payload_o        = out_q.payload;
  assign sync_reset_o            = sync_q;
  assign overrun_o               = overrun_q;
  assign malformed_o             = malformed_q;
endmodule

// File: tb/tb_bsg_gateway_tag_packet_decoder.sv
// Bench for the tag packet decoder: directed scenarios plus a randomized packet stream.
module tb_bsg_gateway_tag_packet_decoder;
  localparam int els_lp = 64;
  localparam int idw_lp = 6;
  localparam int lg_lp  = 4;
  localparam int pw_lp  = 10;
  localparam int run_lp = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic data = 1'b0;
  logic sync_reset, overrun, malformed;

  bsg_gateway_tag_packet_decoder_if #(
    .id_width_p(idw_lp), .lg_width_p(lg_lp), .payload_width_p(pw_lp)
  ) pkt_if ();

  bsg_gateway_tag_packet_decoder #(
    .els_p(els_lp), .lg_width_p(lg_lp), .max_payload_width_p(pw_lp), .reset_run_p(run_lp)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .en_i        (en),
    .data_i      (data),
    .pkt_if      (pkt_if),
    .sync_reset_o(sync_reset),
    .overrun_o   (overrun),
    .malformed_o (malformed)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int check_cnt = 0;
  int obs[$];
  int sync_cnt = 0;
  bit txq[$];

  function automatic int code(input int id, input int dnr, input int len, input int pl);
    return (id << 20) | (dnr << 16) | (len << 12) | pl;
  endfunction

  // Accepted-packet log and reset-pulse counter; tasks only read these.
  always @(posedge clk) begin
    if (!reset && pkt_if.v_o && pkt_if.ready_i)
      obs.push_back(code(int'(pkt_if.node_id_o), int'(pkt_if.data_not_reset_o),
                         int'(pkt_if.len_o), int'(pkt_if.payload_o)));
    if (!reset && sync_reset) sync_cnt++;
  end

  task automatic add_pkt(input int id, input int dnr, input int len, input int pl);
    txq.push_back(1'b1);
    for (int i = 0; i < idw_lp; i++) txq.push_back(((id >> i) & 1) != 0);
    txq.push_back(dnr != 0);
    for (int i = 0; i < lg_lp; i++) txq.push_back(((len >> i) & 1) != 0);
    for (int i = 0; i < len; i++) txq.push_back(((pl >> i) & 1) != 0);
  endtask

  task automatic send_txq(input int gap_mode);
    int gaps;
    for (int i = 0; i < txq.size(); i++) begin
      @(negedge clk); en = 1'b1; data = txq[i];
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk); en = 1'b0; data = 1'($urandom_range(0, 1));
      end
    end
    txq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); en = 1'b0; data = 1'b0; end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; en = 1'b0; data = 1'b0; pkt_if.ready_i = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    pkt_if.ready_i = 1'b0;
    #1;
    check_cnt++; if (pkt_if.v_o !== 1'b0) $display("FAIL reset_v: got %b expected 0", pkt_if.v_o); else pass_cnt++;
    check_cnt++; if (pkt_if.node_id_o !== '0) $display("FAIL reset_id: got %0h expected 0", pkt_if.node_id_o); else pass_cnt++;
    check_cnt++; if (pkt_if.len_o !== '0) $display("FAIL reset_len: got %0h expected 0", pkt_if.len_o); else pass_cnt++;
    check_cnt++; if (pkt_if.payload_o !== '0) $display("FAIL reset_payload: got %0h expected 0", pkt_if.payload_o); else pass_cnt++;
    check_cnt++; if ({sync_reset, overrun, malformed} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {sync_reset, overrun, malformed}); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    add_pkt(5, 1, 10, 'h2A5);
    send_txq(0);
    check_cnt++; if (pkt_if.v_o !== 1'b0) $display("FAIL single_early_v: got %b expected 0", pkt_if.v_o); else pass_cnt++;
    idle(1);
    check_cnt++; if (pkt_if.v_o !== 1'b1) $display("FAIL single_v: got %b expected 1", pkt_if.v_o); else pass_cnt++;
    check_cnt++; if (pkt_if.node_id_o !== 6'd5) $display("FAIL single_id: got %0d expected 5", pkt_if.node_id_o); else pass_cnt++;
    check_cnt++; if (pkt_if.data_not_reset_o !== 1'b1) $display("FAIL single_dnr: got %b expected 1", pkt_if.data_not_reset_o); else pass_cnt++;
    check_cnt++; if (pkt_if.len_o !== 4'd10) $display("FAIL single_len: got %0d expected 10", pkt_if.len_o); else pass_cnt++;
    check_cnt++; if (pkt_if.payload_o !== 10'h2A5) $display("FAIL single_payload: got %0h expected 2a5", pkt_if.payload_o); else pass_cnt++;
    check_cnt++; if ({sync_reset, overrun, malformed} !== 3'b000)
      $display("FAIL single_flags: got %b expected 000", {sync_reset, overrun, malformed}); else pass_cnt++;
    pkt_if.ready_i = 1'b1;
    @(negedge clk); pkt_if.ready_i = 1'b0;
    check_cnt++; if (pkt_if.v_o !== 1'b0) $display("FAIL single_v_clear: got %b expected 0", pkt_if.v_o); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    int base;
    do_reset();
    pkt_if.ready_i = 1'b1;
    base = obs.size();
    add_pkt(63, 0, 0, 0);
    add_pkt(9, 1, 6, 'h2B);
    send_txq(0);
    idle(3);
    check_cnt++; if (obs.size() - base !== 2) $display("FAIL zero_len_count: got %0d expected 2", obs.size() - base); else pass_cnt++;
    check_cnt++; if (obs[base] !== code(63, 0, 0, 0)) $display("FAIL zero_len_pkt: got %0h expected %0h", obs[base], code(63, 0, 0, 0)); else pass_cnt++;
    check_cnt++; if (obs[base+1] !== code(9, 1, 6, 'h2B)) $display("FAIL zero_len_next: got %0h expected %0h", obs[base+1], code(9, 1, 6, 'h2B)); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    add_pkt(1, 1, 4, 'h3);
    send_txq(0); idle(1);
    check_cnt++; if (pkt_if.v_o !== 1'b1) $display("FAIL bp_first_v: got %b expected 1", pkt_if.v_o); else pass_cnt++;
    add_pkt(2, 1, 4, 'hC);
    send_txq(0); idle(2);
    check_cnt++; if (pkt_if.v_o !== 1'b1) $display("FAIL bp_held_v: got %b expected 1", pkt_if.v_o); else pass_cnt++;
    check_cnt++; if (pkt_if.node_id_o !== 6'd1) $display("FAIL bp_held_id: got %0d expected 1", pkt_if.node_id_o); else pass_cnt++;
    check_cnt++; if (pkt_if.payload_o !== 10'h3) $display("FAIL bp_held_payload: got %0h expected 3", pkt_if.payload_o); else pass_cnt++;
    check_cnt++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b expected 1", overrun); else pass_cnt++;

    do_reset();
    add_pkt(1, 1, 4, 'h3);
    send_txq(0); idle(1);
    add_pkt(2, 1, 4, 'hC);
    for (int i = 0; i < txq.size(); i++) begin
      @(negedge clk); en = 1'b1; data = txq[i];
      pkt_if.ready_i = (i == txq.size() - 1);
    end
    txq.delete();
    @(negedge clk); en = 1'b0; pkt_if.ready_i = 1'b0;
    check_cnt++; if (pkt_if.v_o !== 1'b1) $display("FAIL bp_swap_v: got %b expected 1", pkt_if.v_o); else pass_cnt++;
    check_cnt++; if (pkt_if.node_id_o !== 6'd2) $display("FAIL bp_swap_id: got %0d expected 2", pkt_if.node_id_o); else pass_cnt++;
    check_cnt++; if (pkt_if.payload_o !== 10'hC) $display("FAIL bp_swap_payload: got %0h expected c", pkt_if.payload_o); else pass_cnt++;
    check_cnt++; if (overrun !== 1'b0) $display("FAIL bp_swap_overrun: got %b expected 0", overrun); else pass_cnt++;
  endtask

  task automatic test_en_gaps();
    int base;
    do_reset();
    pkt_if.ready_i = 1'b1;
    base = obs.size();
    add_pkt(5, 1, 10, 'h2A5);
    send_txq(1); idle(2);
    check_cnt++; if (obs.size() - base !== 1) $display("FAIL gaps_count: got %0d expected 1", obs.size() - base); else pass_cnt++;
    check_cnt++; if (obs[base] !== code(5, 1, 10, 'h2A5)) $display("FAIL gaps_pkt: got %0h expected %0h", obs[base], code(5, 1, 10, 'h2A5)); else pass_cnt++;
  endtask

  // Header id=63 len=10, payload bit0=0, then a run of ones: the first packet completes on
  // its ninth run bit (payload 0x3FE) and the run lands mid-payload of the next header.
  task automatic test_reset_run();
    int base, sbase;
    do_reset();
    pkt_if.ready_i = 1'b1;
    base = obs.size(); sbase = sync_cnt;
    add_pkt(63, 1, 10, 0);
    repeat (9) void'(txq.pop_back());
    send_txq(0);
    for (int r = 1; r <= run_lp; r++) begin
      @(negedge clk); en = 1'b1; data = 1'b1;
    end
    check_cnt++; if (sync_reset !== 1'b0) $display("FAIL run_early: got %b expected 0", sync_reset); else pass_cnt++;
    @(negedge clk); en = 1'b1; data = 1'b0;
    check_cnt++; if (sync_reset !== 1'b1) $display("FAIL run_pulse: got %b expected 1", sync_reset); else pass_cnt++;
    @(negedge clk); en = 1'b0;
    check_cnt++; if (sync_reset !== 1'b0) $display("FAIL run_pulse_end: got %b expected 0", sync_reset); else pass_cnt++;
    add_pkt(2, 1, 3, 'h5);
    send_txq(0); idle(3);
    check_cnt++; if (sync_cnt - sbase !== 1) $display("FAIL run_pulse_count: got %0d expected 1", sync_cnt - sbase); else pass_cnt++;
    check_cnt++; if (obs.size() - base !== 2) $display("FAIL run_pkt_count: got %0d expected 2", obs.size() - base); else pass_cnt++;
    check_cnt++; if (obs[base] !== code(63, 1, 10, 'h3FE)) $display("FAIL run_pre_pkt: got %0h expected %0h", obs[base], code(63, 1, 10, 'h3FE)); else pass_cnt++;
    check_cnt++; if (obs[base+1] !== code(2, 1, 3, 'h5)) $display("FAIL run_post_pkt: got %0h expected %0h", obs[base+1], code(2, 1, 3, 'h5)); else pass_cnt++;
  endtask

  task automatic test_malformed();
    int base;
    do_reset();
    pkt_if.ready_i = 1'b1;
    base = obs.size();
    add_pkt(3, 1, 15, int'($urandom_range(0, 'h7FFF)));
    txq.push_back(1'b0);
    add_pkt(4, 0, 7, 'h55);
    send_txq(0); idle(3);
    check_cnt++; if (malformed !== 1'b1) $display("FAIL malformed_flag: got %b expected 1", malformed); else pass_cnt++;
    check_cnt++; if (obs.size() - base !== 1) $display("FAIL malformed_count: got %0d expected 1", obs.size() - base); else pass_cnt++;
    check_cnt++; if (obs[base] !== code(4, 0, 7, 'h55)) $display("FAIL malformed_next: got %0h expected %0h", obs[base], code(4, 0, 7, 'h55)); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    add_pkt(1, 1, 4, 'h3);
    send_txq(0); idle(1);
    add_pkt(7, 1, 8, 'hFF);
    repeat (5) void'(txq.pop_back());
    send_txq(0);
    #2 reset = 1'b1;
    #1;
    check_cnt++; if (pkt_if.v_o !== 1'b0) $display("FAIL midreset_v: got %b expected 0", pkt_if.v_o); else pass_cnt++;
    check_cnt++; if (pkt_if.payload_o !== '0) $display("FAIL midreset_payload: got %0h expected 0", pkt_if.payload_o); else pass_cnt++;
    @(negedge clk); reset = 1'b0; en = 1'b0; pkt_if.ready_i = 1'b1;
    base = obs.size();
    add_pkt(6, 1, 5, 'h15);
    send_txq(0); idle(3);
    check_cnt++; if (obs.size() - base !== 1) $display("FAIL midreset_count: got %0d expected 1", obs.size() - base); else pass_cnt++;
    check_cnt++; if (obs[base] !== code(6, 1, 5, 'h15)) $display("FAIL midreset_pkt: got %0h expected %0h", obs[base], code(6, 1, 5, 'h15)); else pass_cnt++;
  endtask

  task automatic test_random();
    int base, sbase, id, dnr, len, pl;
    int expq[$];
    bit any_bad;
    do_reset();
    pkt_if.ready_i = 1'b1;
    base = obs.size(); sbase = sync_cnt; any_bad = 0;
    for (int n = 0; n < 24; n++) begin
      id  = int'($urandom_range(0, els_lp - 1));
      dnr = int'($urandom_range(0, 1));
      len = int'($urandom_range(0, 15));
      pl  = int'($urandom) & ((1 << len) - 1);
      add_pkt(id, dnr, len, pl);
      repeat (int'($urandom_range(1, 3))) txq.push_back(1'b0);
      if (len <= pw_lp) expq.push_back(code(id, dnr, len, pl));
      else any_bad = 1;
    end
    send_txq(2); idle(3);
    check_cnt++; if (obs.size() - base !== expq.size()) $display("FAIL rand_count: got %0d expected %0d", obs.size() - base, expq.size()); else pass_cnt++;
    for (int k = 0; k < expq.size(); k++) begin
      check_cnt++; if (obs[base+k] !== expq[k]) $display("FAIL rand_pkt%0d: got %0h expected %0h", k, obs[base+k], expq[k]); else pass_cnt++;
    end
    check_cnt++; if (malformed !== any_bad) $display("FAIL rand_malformed: got %b expected %b", malformed, any_bad); else pass_cnt++;
    check_cnt++; if (overrun !== 1'b0) $display("FAIL rand_overrun: got %b expected 0", overrun); else pass_cnt++;
    check_cnt++; if (sync_cnt - sbase !== 0) $display("FAIL rand_sync: got %0d expected 0", sync_cnt - sbase); else pass_cnt++;
  endtask

  initial begin
    pkt_if.ready_i = 1'b0;
    test_reset();
    test_single();
    test_zero_len();
    test_backpressure();
    test_en_gaps();
    test_reset_run();
    test_malformed();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
